// File: rtl/axi_lite_reg_bridge_pkg.sv
// Shared types and helpers for the AXI-Lite register bridge.
//   axi_resp_t    - AXI response encoding
//   write_state_t - write-path FSM states
//   read_state_t  - read-path FSM states
//   word_index()  - extracts the register word index from a byte address
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_WAIT_ERR,
        W_RESP
    } write_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_RESP
    } read_state_t;

    // Word index = addr[reg_aw+addr_lsb-1:addr_lsb], zero-extended to 32 bits.
    function automatic logic [31:0] word_index(input logic [63:0] addr,
                                               input int addr_lsb,
                                               input int reg_aw);
        logic [63:0] mask;
        mask = (64'd1 << reg_aw) - 64'd1;
        return 32'((addr >> addr_lsb) & mask);
    endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// One-entry valid/ready holding register.
//   en       - allows acceptance (held low right after reset)
//   in_valid / in_ready / in_data - upstream handshake
//   clr      - drops the held entry; ready returns the following cycle
//   held / data - current entry
module axi_lite_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    output logic             held,
    output logic [WIDTH-1:0] data
);

    logic             held_q, held_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready = en & ~held_q;
    assign held     = held_q;
    assign data     = data_q;

    always_comb begin
        held_d = held_q;
        data_d = data_q;
        if (clr) begin
            held_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            held_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else begin
            held_q <= held_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave bridging onto a single shared register-file port.
//   AXI side : aw*/w*/b* write channels, ar*/r* read channels
//   reg side : reg_addr/reg_wdata/reg_wstrb with single-cycle reg_wen/reg_ren,
//              reg_rdata/reg_error returned RD_LATENCY cycles after reg_ren
// AW, W and AR each land in a one-entry holding register; a read and a write
// compete for the register port with round-robin on contention.
module axi_lite_reg_bridge
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int NUM_REGS       = 16,
    parameter int RD_LATENCY     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0]     reg_wdata,
    output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
    output logic                      reg_wen,
    output logic                      reg_ren,
    input  logic [DATA_WIDTH-1:0]     reg_rdata,
    input  logic                      reg_error
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    // Holds all readies low through reset and for the first cycle after it.
    logic alive_q;

    logic                    aw_held, w_held, ar_held;
    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic                    b_hs, r_hs;

    assign b_hs = bvalid & bready;
    assign r_hs = rvalid & rready;

    axi_lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk(clk), .rst(rst), .en(alive_q),
        .in_valid(awvalid), .in_ready(awready), .in_data(awaddr),
        .clr(b_hs), .held(aw_held), .data(aw_addr)
    );

    axi_lite_hold_reg #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_hold (
        .clk(clk), .rst(rst), .en(alive_q),
        .in_valid(wvalid), .in_ready(wready), .in_data({wstrb, wdata}),
        .clr(b_hs), .held(w_held), .data({w_strb, w_data})
    );

    axi_lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
        .clk(clk), .rst(rst), .en(alive_q),
        .in_valid(arvalid), .in_ready(arready), .in_data(araddr),
        .clr(r_hs), .held(ar_held), .data(ar_addr)
    );

    // Local decode: out-of-range wins over misalignment.
    logic [31:0] aw_idx, ar_idx;
    axi_resp_t   aw_dec, ar_dec;

    assign aw_idx = word_index(64'(aw_addr), ADDR_LSB, REG_ADDR_WIDTH);
    assign ar_idx = word_index(64'(ar_addr), ADDR_LSB, REG_ADDR_WIDTH);

    always_comb begin
        aw_dec = OKAY;
        if (aw_idx >= 32'(NUM_REGS))                aw_dec = DECERR;
        else if (aw_addr[ADDR_LSB-1:0] != '0)        aw_dec = SLVERR;
        ar_dec = OKAY;
        if (ar_idx >= 32'(NUM_REGS))                ar_dec = DECERR;
        else if (ar_addr[ADDR_LSB-1:0] != '0)        ar_dec = SLVERR;
    end

    write_state_t            w_state_q, w_state_d;
    read_state_t             r_state_q, r_state_d;
    axi_resp_t               bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    last_rd_q, last_rd_d;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
    logic [STRB_W-1:0]       reg_wstrb_q, reg_wstrb_d;
    logic                    reg_wen_q, reg_wen_d, reg_ren_q, reg_ren_d;

    assign bvalid    = (w_state_q == W_RESP);
    assign rvalid    = (r_state_q == R_RESP);
    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wstrb = reg_wstrb_q;
    assign reg_wen   = reg_wen_q;
    assign reg_ren   = reg_ren_q;

    // Port is owned from the strobe cycle until read data has been captured.
    logic port_busy, w_elig, r_elig, w_gnt, r_gnt;

    assign port_busy = (w_state_q == W_ISSUE) | (r_state_q == R_ISSUE) |
                       (r_state_q == R_WAIT);
    assign w_elig = (w_state_q == W_IDLE) & aw_held & w_held & ~bvalid & ~port_busy;
    assign r_elig = (r_state_q == R_IDLE) & ar_held & ~rvalid & ~port_busy;
    // last_rd_q only moves on contended cycles so collisions alternate.
    assign r_gnt  = r_elig & (~w_elig | ~last_rd_q);
    assign w_gnt  = w_elig & ~r_gnt;
    assign last_rd_d = (w_elig & r_elig) ? r_gnt : last_rd_q;

    // Register-port drive, registered so strobes land in grant cycle + 1.
    always_comb begin
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wstrb_d = reg_wstrb_q;
        reg_wen_d   = 1'b0;
        reg_ren_d   = 1'b0;
        if (w_gnt && aw_dec == OKAY) begin
            reg_wen_d   = 1'b1;
            reg_addr_d  = aw_idx[REG_ADDR_WIDTH-1:0];
            reg_wdata_d = w_data;
            reg_wstrb_d = w_strb;
        end
        if (r_gnt && ar_dec == OKAY) begin
            reg_ren_d  = 1'b1;
            reg_addr_d = ar_idx[REG_ADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (w_gnt) begin
                    if (aw_dec != OKAY) begin
                        bresp_d   = aw_dec;
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_ISSUE;
                    end
                end
            end
            W_ISSUE: begin
                bresp_d   = reg_error ? SLVERR : OKAY;
                w_state_d = W_WAIT_ERR;
            end
            W_WAIT_ERR: w_state_d = W_RESP;
            W_RESP:     if (bready) w_state_d = W_IDLE;
            default:    w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (r_gnt) begin
                    if (ar_dec != OKAY) begin
                        rresp_d   = ar_dec;
                        rdata_d   = '0;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_ISSUE;
                    end
                end
            end
            R_ISSUE: begin
                if (RD_LATENCY == 0) begin
                    rdata_d   = reg_rdata;
                    rresp_d   = reg_error ? SLVERR : OKAY;
                    r_state_d = R_RESP;
                end else begin
                    cnt_d     = 2'd1;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt_q == 2'(RD_LATENCY)) begin
                    rdata_d   = reg_rdata;
                    rresp_d   = reg_error ? SLVERR : OKAY;
                    r_state_d = R_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            R_RESP:  if (rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q     <= 1'b0;
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            bresp_q     <= OKAY;
            rresp_q     <= OKAY;
            rdata_q     <= '0;
            cnt_q       <= '0;
            last_rd_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
            reg_wen_q   <= 1'b0;
            reg_ren_q   <= 1'b0;
        end else begin
            alive_q     <= 1'b1;
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            last_rd_q   <= last_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wstrb_q <= reg_wstrb_d;
            reg_wen_q   <= reg_wen_d;
            reg_ren_q   <= reg_ren_d;
        end
    end

endmodule
